serial_subtractor: RTL and testbench

- Multi-cycle, digit-serial two's-complement subtractor computing a − b − borrow_in over WIDTH bits, processing DIGIT bits per clock from the LSB up.
- Generalises the single-bit full-subtractor cell to parametrised width, chains borrow across cycles and adds a start/busy/done handshake.
- Reports borrow-out, zero and signed-overflow flags.
- Serves datapaths that trade latency for area: one DIGIT-wide subtract slice reused WIDTH/DIGIT times.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_sub_slice.sv | 26 ++
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit params_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  // Step counter needs at least one bit even when a single step suffices.
  function automatic int cnt_width(input int nstep);
    int w;
    w = $clog2(nstep);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// DIGIT-wide ripple-borrow subtract slice: d = x - y - bin.
module sub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & (y[i] ^ br[i])) | (y[i] & br[i]);
    end
  end

  assign bout = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - borrow_in: one DIGIT slice reused NSTEP times, LSB digit first.
// Handshake: start is accepted on any edge where busy=0 (IDLE or DONE); done pulses one cycle when results update.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = cnt_width(NSTEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  generate
    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_subtractor: DIGIT must divide WIDTH");
    end
  endgenerate

  state_t           state_q, state_n;
  logic [WIDTH-1:0] a_q, b_q, wdiff_q, res;
  logic             wborrow_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] x, y, d;
  logic             bout, accept, last;
  int unsigned      base;

  assign last = (cnt_q == LAST);

  // Select the current digit of each operand and splice its result into the working diff.
  always_comb begin
    base = int'(cnt_q) * DIGIT;
    x    = a_q[base +: DIGIT];
    y    = b_q[base +: DIGIT];
    res  = wdiff_q;
    res[base +: DIGIT] = d;
  end

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (x),
    .y    (y),
    .bin  (wborrow_q),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN:  if (last) state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      wdiff_q    <= '0;
      wborrow_q  <= 1'b0;
      cnt_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      wdiff_q   <= '0;
      wborrow_q <= borrow_in;
      cnt_q     <= '0;
    end else if (state_q == ST_RUN) begin
      wdiff_q   <= res;
      wborrow_q <= bout;
      cnt_q     <= cnt_q + 1'b1;
      if (last) begin
        diff       <= res;
        borrow_out <= bout;
        zero       <= (res == '0);
        ovf        <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res[WIDTH-1] ^ a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (DIGIT=4,1,16) against a cycle-level arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       start_v = '0;
  logic [2:0]       bin_v   = '0;
  logic [2:0][15:0] a_v     = '0;
  logic [2:0][15:0] b_v     = '0;
  logic [2:0]       busy_v, done_v, bo_v, zero_v, ovf_v;
  logic [2:0][15:0] diff_v;
  logic [2:0][1:0]  dbg_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    serial_subtractor #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[g]),
      .a          (a_v[g]),
      .b          (b_v[g]),
      .borrow_in  (bin_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .diff       (diff_v[g]),
      .borrow_out (bo_v[g]),
      .zero       (zero_v[g]),
      .ovf        (ovf_v[g]),
      .state_dbg  (dbg_v[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit checking = 1'b0;

  function automatic int nstep(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[inst %0d] got=%h want=%h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  // Behavioural model: an accepted op yields its arithmetic result NSTEP edges later.
  int          m_rem [3] = '{0, 0, 0};
  logic        m_done[3] = '{0, 0, 0};
  logic [15:0] m_diff[3] = '{0, 0, 0};
  logic        m_bo  [3] = '{0, 0, 0};
  logic        m_zero[3] = '{0, 0, 0};
  logic        m_ovf [3] = '{0, 0, 0};
  logic [15:0] p_diff[3];
  logic        p_bo[3], p_ovf[3];

  always @(posedge clk) begin
    logic [16:0] t;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_rem[k] = 0; m_done[k] = 0; m_diff[k] = 0;
        m_bo[k] = 0; m_zero[k] = 0; m_ovf[k] = 0;
      end else if (m_rem[k] > 0) begin
        m_done[k] = 0;
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_done[k] = 1;
          m_diff[k] = p_diff[k];
          m_bo[k]   = p_bo[k];
          m_zero[k] = (p_diff[k] == 16'h0);
          m_ovf[k]  = p_ovf[k];
        end
      end else begin
        m_done[k] = 0;
        if (start_v[k]) begin
          t = {1'b0, a_v[k]} - {1'b0, b_v[k]} - {16'h0, bin_v[k]};
          p_diff[k] = t[15:0];
          p_bo[k]   = t[16];
          p_ovf[k]  = (a_v[k][15] != b_v[k][15]) && (t[15] != a_v[k][15]);
          m_rem[k]  = nstep(k);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        chk("busy", k, 32'(busy_v[k]), 32'(m_rem[k] > 0));
        chk("done", k, 32'(done_v[k]), 32'(m_done[k]));
        chk("diff", k, 32'(diff_v[k]), 32'(m_diff[k]));
        chk("borrow_out", k, 32'(bo_v[k]), 32'(m_bo[k]));
        chk("zero", k, 32'(zero_v[k]), 32'(m_zero[k]));
        chk("ovf", k, 32'(ovf_v[k]), 32'(m_ovf[k]));
      end
    end
  end

  task automatic drive(input int k, input logic [15:0] a, input logic [15:0] b, input logic bi);
    start_v[k] = 1'b1;
    a_v[k]     = a;
    b_v[k]     = b;
    bin_v[k]   = bi;
  endtask

  task automatic go(input int k, input logic [15:0] a, input logic [15:0] b, input logic bi,
                    output int t0);
    @(posedge clk); #1;
    drive(k, a, b, bi);
    @(posedge clk); #1;
    t0 = cyc;
    start_v[k] = 1'b0;
  endtask

  // Returns at the negedge where done is high; latency is measured from the accepting edge.
  task automatic wait_done(input int k, input int t0);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_v[k]) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", k, 32'd0, 32'd1);
    else       chk("latency", k, 32'(cyc - t0), 32'(nstep(k)));
  endtask

  task automatic expect_out(input string nm, input int k, input logic [15:0] d,
                            input logic bo, input logic z, input logic ov);
    chk({nm, "_diff"}, k, 32'(diff_v[k]), 32'(d));
    chk({nm, "_bo"},   k, 32'(bo_v[k]),   32'(bo));
    chk({nm, "_zero"}, k, 32'(zero_v[k]), 32'(z));
    chk({nm, "_ovf"},  k, 32'(ovf_v[k]),  32'(ov));
  endtask

  task automatic run_suite(input int k);
    int t0;
    go(k, 16'h1234, 16'h0235, 1'b0, t0);
    wait_done(k, t0);
    expect_out("basic", k, 16'h0FFF, 1'b0, 1'b0, 1'b0);

    go(k, 16'h0000, 16'h0001, 1'b0, t0);
    wait_done(k, t0);
    expect_out("under", k, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    go(k, 16'h8000, 16'h0001, 1'b0, t0);
    wait_done(k, t0);
    expect_out("ovf", k, 16'h7FFF, 1'b0, 1'b0, 1'b1);

    go(k, 16'h0005, 16'h0004, 1'b1, t0);
    wait_done(k, t0);
    expect_out("zero", k, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Second start with new operands arrives while the first op is in flight.
    @(posedge clk); #1;
    drive(k, 16'h1234, 16'h0235, 1'b0);
    @(posedge clk); #1;
    t0 = cyc;
    drive(k, 16'hFFFF, 16'h0001, 1'b1);
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    wait_done(k, t0);
    expect_out("ignore", k, 16'h0FFF, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held during the DONE cycle.
    go(k, 16'h1234, 16'h0235, 1'b0, t0);
    wait_done(k, t0);
    drive(k, 16'h0010, 16'h0020, 1'b0);
    @(posedge clk); #1;
    t0 = cyc;
    start_v[k] = 1'b0;
    wait_done(k, t0);
    expect_out("b2b", k, 16'hFFF0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
      chk("rst_done", k, 32'(done_v[k]), 32'd0);
      expect_out("rst", k, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    checking = 1'b1;

    for (int k = 0; k < 3; k++) run_suite(k);

    // Mid-operation reset on all instances.
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) drive(k, 16'h0000, 16'h0001, 1'b0);
    @(posedge clk); #1;
    start_v = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_busy", k, 32'(busy_v[k]), 32'd0);
      chk("abort_done", k, 32'(done_v[k]), 32'd0);
      expect_out("abort", k, 16'h0000, 1'b0, 1'b0, 1'b0);
    end

    for (int n = 0; n < 60; n++) begin
      int k;
      logic [15:0] ra, rb;
      k  = $urandom_range(2, 0);
      ra = 16'($urandom_range(16'hFFFF, 0));
      rb = (n % 5 == 0) ? ra : 16'($urandom_range(16'hFFFF, 0));
      go(k, ra, rb, 1'($urandom_range(1, 0)), t0);
      wait_done(k, t0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
